// File: rtl/bin_img_stream_gen.sv
// Binary video stream source: emits complete vsync/href/bit frames with programmable
// blanking and a per-frame latched 1-bit pattern (zero, checkerboard, rectangle, LFSR).
module bin_img_stream_gen #(
  parameter logic [10:0] IMG_HDISP = 11'd1280,
  parameter logic [10:0] IMG_VDISP = 11'd720,
  parameter int          H_BLANK   = 16,
  parameter int          V_FRONT   = 4,
  parameter int          V_BACK    = 4,
  parameter int          FRAME_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [10:0] box_x0,
  input  logic [10:0] box_x1,
  input  logic [10:0] box_y0,
  input  logic [10:0] box_y1,
  output logic        post_img_vsync,
  output logic        post_img_href,
  output logic        post_img_bit,
  output logic        frame_done
);

  localparam int BLK_A   = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
  localparam int BLK_B   = (V_BACK > FRAME_GAP) ? V_BACK : FRAME_GAP;
  localparam int BLK_MAX = (BLK_A > BLK_B) ? BLK_A : BLK_B;
  localparam int CW      = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BACK - 1);
  localparam logic [CW-1:0] FG_LAST = CW'(FRAME_GAP - 1);
  localparam logic [10:0]   X_LAST  = IMG_HDISP - 11'd1;
  localparam logic [10:0]   Y_LAST  = IMG_VDISP - 11'd1;
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    VFRONT,
    ACTIVE,
    HBLANK,
    VBACK,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [10:0]   x;
  logic [10:0]   x_nxt;
  logic [10:0]   y;
  logic [10:0]   y_nxt;
  logic          latch;

  logic [15:0]   lfsr;
  logic [1:0]    pat;
  logic [10:0]   bx0;
  logic [10:0]   bx1;
  logic [10:0]   by0;
  logic [10:0]   by1;

  logic          vsync_p1;
  logic          href_p1;
  logic          bit_p1;
  logic          done_p1;

  // Fibonacci step, taps 16,14,13,11 seen from the output end as bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic pixel_bit(
    input logic [1:0]  p,
    input logic [10:0] px,
    input logic [10:0] py,
    input logic [10:0] x0,
    input logic [10:0] x1,
    input logic [10:0] y0,
    input logic [10:0] y1,
    input logic        noise
  );
    logic b;
    b = 1'b0;
    case (p)
      2'd1:    b = px[0] ^ py[0];
      2'd2:    b = (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
      2'd3:    b = noise;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x;
    y_nxt     = y;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          latch     = 1'b1;
          state_nxt = VFRONT;
          cnt_nxt   = '0;
        end
      end
      VFRONT: begin
        if (cnt == VF_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          x_nxt     = '0;
          y_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACTIVE: begin
        if (x == X_LAST) begin
          state_nxt = HBLANK;
          cnt_nxt   = '0;
        end else begin
          x_nxt = x + 11'd1;
        end
      end
      HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_nxt = '0;
          if (y == Y_LAST) begin
            state_nxt = VBACK;
          end else begin
            state_nxt = ACTIVE;
            x_nxt     = '0;
            y_nxt     = y + 11'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      VBACK: begin
        if (cnt == VB_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == FG_LAST) begin
          cnt_nxt = '0;
          if (enable) begin
            latch     = 1'b1;
            state_nxt = VFRONT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p1: outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      lfsr     <= LFSR_SEED;
      pat      <= '0;
      bx0      <= '0;
      bx1      <= '0;
      by0      <= '0;
      by1      <= '0;
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      bit_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      x   <= x_nxt;
      y   <= y_nxt;
      if (latch) begin
        pat  <= pattern_sel;
        bx0  <= box_x0;
        bx1  <= box_x1;
        by0  <= box_y0;
        by1  <= box_y1;
        lfsr <= LFSR_SEED;
      end else if (state_nxt == ACTIVE) begin
        // lfsr[0] is this pixel's noise bit; the register then moves to the next one.
        lfsr <= lfsr_step(lfsr);
      end
      vsync_p1 <= (state_nxt == VFRONT) || (state_nxt == ACTIVE) ||
                  (state_nxt == HBLANK) || (state_nxt == VBACK);
      href_p1  <= (state_nxt == ACTIVE);
      bit_p1   <= (state_nxt == ACTIVE) ?
                  pixel_bit(pat, x_nxt, y_nxt, bx0, bx1, by0, by1, lfsr[0]) : 1'b0;
      done_p1  <= (state_nxt == GAP) && (state != GAP);
    end
  end

  assign post_img_vsync = vsync_p1;
  assign post_img_href  = href_p1;
  assign post_img_bit   = bit_p1;
  assign frame_done     = done_p1;

endmodule

// File: doc/bin_img_stream_gen.md
Name: bin_img_stream_gen

Overview:
- Binary video stream source that drives the per_img_vsync / per_img_href / per_img_bit interface used by the 1-bit morphology and compare filters.
- Generates complete frames with programmable blanking and a selectable 1-bit pattern: zero, checkerboard, rectangle, or LFSR noise.
- Serves as the on-chip stimulus for bring-up of the binary pipeline and for closed-loop tests of downstream filters without the sensor.

Parameters:
- IMG_HDISP, 11'd1280, active pixels per line
- IMG_VDISP, 11'd720, active lines per frame
- H_BLANK, 16, href-low cycles after every active line, ≥1
- V_FRONT, 4, vsync-high/href-low cycles before the first line, ≥1
- V_BACK, 4, vsync-high/href-low cycles after the last line's blank, ≥1
- FRAME_GAP, 8, vsync-low cycles between frames, ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- enable  in  1  level. Start or continue frame generation.
- pattern_sel  in  2  pattern select: 0 zero, 1 checkerboard, 2 rectangle, 3 LFSR
- box_x0, box_x1  in  11 each  rectangle column bounds, inclusive
- box_y0, box_y1  in  11 each  rectangle row bounds, inclusive
- post_img_vsync  out  1  frame valid, high for the whole frame
- post_img_href  out  1  pixel valid
- post_img_bit  out  1  pixel value, 0 whenever href=0
- frame_done  out  1  one-cycle pulse on the first vsync-low cycle after a frame

Behaviour:
- All outputs are registered.
- Reset: all outputs 0, FSM in IDLE, counters 0, LFSR = 16'hACE1.
- Reset takes priority over every other event. Reset asserted mid-frame forces all outputs to 0 on the next edge; no frame_done is produced.
- FSM states: IDLE, VFRONT, ACTIVE, HBLANK, VBACK, GAP.
  - IDLE: all outputs 0. On enable=1, latch pattern_sel and box_*, go to VFRONT. First vsync=1 appears 1 cycle after enable is sampled high.
  - VFRONT: vsync=1, href=0 for V_FRONT cycles, then ACTIVE with y=0.
  - ACTIVE: vsync=1, href=1 for IMG_HDISP cycles, x = 0..IMG_HDISP-1, then HBLANK.
  - HBLANK: href=0 for H_BLANK cycles. Then, if y = IMG_VDISP-1, go to VBACK; else y+1 and go to ACTIVE.
  - VBACK: vsync=1, href=0 for V_BACK cycles, then GAP.
  - GAP: vsync=0 for FRAME_GAP cycles; frame_done=1 on the first GAP cycle only. At GAP end: if enable=1, re-latch controls and go to VFRONT; else go to IDLE.
- vsync-high length per frame = V_FRONT + IMG_VDISP*(IMG_HDISP+H_BLANK) + V_BACK cycles, exactly.
- Controls:
  - enable deasserted mid-frame: the current frame completes; the FSM stops after GAP.
  - pattern_sel and box_* changes mid-frame have no effect until the next frame latch.
- Pixel bit, valid only when href=1 and otherwise 0:
  - pattern 0: 0.
  - pattern 1: x[0] XOR y[0].
  - pattern 2: 1 iff box_x0 ≤ x ≤ box_x1 and box_y0 ≤ y ≤ box_y1, unsigned compare. x0>x1 or y0>y1 gives an all-zero frame.
  - pattern 3: lfsr[0].
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shift toward bit 0.
  - Loaded with 16'hACE1 at every frame latch.
  - Advances once per href=1 cycle, after the current bit is output.
  - Every noise frame is therefore bit-identical.
- Counters are 11 bits; x and y never exceed IMG_HDISP-1 and IMG_VDISP-1. Blank counters are sized by $clog2 of the largest blank parameter.

Test Plan (IMG_HDISP=8, IMG_VDISP=4, H_BLANK=2, V_FRONT=3, V_BACK=3, FRAME_GAP=5):
- Timing: enable=1 held, pattern 0 → vsync high exactly 46 cycles. 4 href bursts of 8 cycles, separated by 2 low cycles. First href 3 cycles after the vsync rise. vsync low 5 cycles between frames. frame_done is a single pulse on each vsync fall. bit=0 throughout.
- Checkerboard: pattern 1 → line 0 bits 0,1,0,1,0,1,0,1; line 1 bits 1,0,1,0,1,0,1,0. 16 ones per frame.
- Rectangle: pattern 2, box x0=2 x1=5 y0=1 y1=2 → ones only at x 2..5 on lines 1 and 2, 8 ones per frame. Then x0=6 x1=5 → 0 ones.
- LFSR: pattern 3, two consecutive frames → identical 32-bit sequences matching the reference model seeded with 16'hACE1. First bit = 1.
- Control timing: pattern_sel changed from 1 to 2 mid-frame → the current frame stays checkerboard, the next frame is rectangle. enable dropped mid-frame → the frame completes, frame_done pulses, then outputs stay 0 in IDLE.
- Reset: rst=1 for 1 cycle during ACTIVE at line 2 → all outputs 0 the next cycle, no frame_done. With enable=1 after release, vsync rises 1 cycle later and the new frame starts at line 0.
